// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with load-use stall, multi-bubble hold and flush.
module id_ex_hazard_reg #(
    parameter int XLEN       = 32,
    parameter int LU_BUBBLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [8:0]      id_ctrl,
    input  logic            ex_flush,
    output logic            ID_EXValid,
    output logic [XLEN-1:0] ID_EXPC,
    output logic [4:0]      ID_EXRs1,
    output logic [4:0]      ID_EXRs2,
    output logic [4:0]      ID_EXRd,
    output logic [XLEN-1:0] ID_EXRd1,
    output logic [XLEN-1:0] ID_EXRd2,
    output logic [XLEN-1:0] ID_EXImm,
    output logic [8:0]      ID_EXCtrl,
    output logic            PCWrite,
    output logic            IF_IDWrite,
    output logic [15:0]     stall_count
);
    typedef enum logic {RUN, HOLD} state_t;
    localparam logic [1:0] HOLD_INIT = 2'(LU_BUBBLES - 1);
    state_t     state, state_nxt;
    logic [1:0] hold_cnt, hold_cnt_nxt;
    logic       hazard, stall, bubble;

    // ID_EXCtrl[7] is MemRead: only a load in EX can create a load-use hazard
    assign hazard = ID_EXValid & ID_EXCtrl[7] & (ID_EXRd != 5'd0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == ID_EXRd)) | (id_uses_rs2 & (id_rs2 == ID_EXRd)));
    assign stall      = ~ex_flush & (((state == RUN) & hazard) | (state == HOLD));
    assign bubble     = ex_flush | stall;
    assign PCWrite    = ~stall;
    assign IF_IDWrite = ~stall;

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        if (ex_flush) begin
            state_nxt    = RUN;
            hold_cnt_nxt = 2'd0;
        end else if (state == HOLD) begin
            hold_cnt_nxt = hold_cnt - 2'd1;
            state_nxt    = (hold_cnt == 2'd1) ? RUN : HOLD;
        end else if (hazard && LU_BUBBLES > 1) begin
            state_nxt    = HOLD;
            hold_cnt_nxt = HOLD_INIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            hold_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // a bubble zeroes indices too, so the forwarding unit never matches on it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ID_EXValid <= 1'b0;
            ID_EXPC    <= '0;
            ID_EXRs1   <= '0;
            ID_EXRs2   <= '0;
            ID_EXRd    <= '0;
            ID_EXRd1   <= '0;
            ID_EXRd2   <= '0;
            ID_EXImm   <= '0;
            ID_EXCtrl  <= '0;
        end else begin
            ID_EXValid <= id_valid & ~bubble;
            ID_EXPC    <= bubble ? '0 : id_pc;
            ID_EXRs1   <= bubble ? '0 : id_rs1;
            ID_EXRs2   <= bubble ? '0 : id_rs2;
            ID_EXRd    <= bubble ? '0 : id_rd;
            ID_EXRd1   <= bubble ? '0 : id_rd1;
            ID_EXRd2   <= bubble ? '0 : id_rd2;
            ID_EXImm   <= bubble ? '0 : id_imm;
            ID_EXCtrl  <= bubble ? '0 : id_ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= 16'd0;
        else if (stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
endmodule
